// File: rtl/jtag_host_driver.sv
`timescale 1ns/1ps
// JTAG host: turns word-level commands (TAP reset, IR/DR shift, idle clocks) into
// tck/tms/tdi/trst sequences, keeping the target TAP parked in Run-Test/Idle.
module jtag_host_driver #(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  output logic               trst,
  input  logic               tdo
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PER_W = (LEN_W > 3) ? LEN_W : 3;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;

  // Completion returns straight to IDLE; the rsp_valid cycle doubles as the first IDLE cycle.
  typedef enum logic [2:0] {S_IDLE, S_RST, S_PRE, S_SHIFT, S_POST, S_RUN} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         op_reg, op_next;
  logic [LEN_W-1:0]   len_reg, len_next, len_eff;
  logic [MAX_LEN-1:0] data_reg, data_next;
  logic [MAX_LEN-1:0] cap_reg, cap_next;
  logic [MAX_LEN-1:0] rsp_data_reg, rsp_data_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic [PER_W-1:0]   per_reg, per_next, per_inc;
  logic [IDX_W-1:0]   idx_reg, idx_next, idx_inc;
  logic               high_reg, high_next;
  logic               tck_reg, tck_next, tms_reg, tms_next;
  logic               tdi_reg, tdi_next, trst_reg, trst_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic               cmd_ready_reg, cmd_ready_next;
  logic               busy_reg, busy_next;
  logic               half_end, last_bit, done;

  always_comb begin
    len_eff = cmd_len;
    if (cmd_len > LEN_W'(MAX_LEN))
      len_eff = LEN_W'(MAX_LEN);
    else if (cmd_len == '0 && (cmd_op == OP_IR || cmd_op == OP_DR))
      len_eff = LEN_W'(1);
  end

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    len_next       = len_reg;
    data_next      = data_reg;
    cap_next       = cap_reg;
    rsp_data_next  = rsp_data_reg;
    div_next       = div_reg;
    per_next       = per_reg;
    idx_next       = idx_reg;
    high_next      = high_reg;
    tck_next       = tck_reg;
    tms_next       = tms_reg;
    tdi_next       = tdi_reg;
    trst_next      = trst_reg;
    rsp_valid_next = 1'b0;
    cmd_ready_next = cmd_ready_reg;
    busy_next      = busy_reg;
    done           = 1'b0;
    half_end       = (div_reg == DIV_W'(CLK_DIV - 1));
    last_bit       = (LEN_W'(idx_reg) == len_reg - LEN_W'(1));
    idx_inc        = idx_reg + IDX_W'(1);
    per_inc        = per_reg + PER_W'(1);

    case (state_reg)
      S_IDLE: begin
        cmd_ready_next = 1'b1;
        if (cmd_valid && cmd_ready_reg) begin
          op_next        = cmd_op;
          len_next       = len_eff;
          data_next      = cmd_data;
          cap_next       = '0;
          div_next       = '0;
          per_next       = '0;
          idx_next       = '0;
          high_next      = 1'b0;
          tck_next       = 1'b0;
          tdi_next       = 1'b0;
          trst_next      = 1'b1;
          cmd_ready_next = 1'b0;
          busy_next      = 1'b1;
          case (cmd_op)
            OP_RESET: begin
              state_next = S_RST;
              tms_next   = 1'b1;
              trst_next  = 1'b0;
            end
            OP_IR, OP_DR: begin
              state_next = S_PRE;
              tms_next   = 1'b1;
            end
            default: begin
              tms_next = 1'b0;
              if (len_eff == '0) begin
                rsp_valid_next = 1'b1;
                cmd_ready_next = 1'b1;
                busy_next      = 1'b0;
                rsp_data_next  = '0;
              end else begin
                state_next = S_RUN;
              end
            end
          endcase
        end
      end

      default: begin
        div_next = half_end ? '0 : div_reg + DIV_W'(1);
        if (half_end && !high_reg) begin
          high_next = 1'b1;
          tck_next  = 1'b1;
          if (state_reg == S_SHIFT)
            cap_next[idx_reg] = tdo;
        end else if (half_end) begin
          // Period boundary: tck falls and tms/tdi/trst move to the next period's values.
          high_next = 1'b0;
          tck_next  = 1'b0;
          per_next  = per_inc;
          case (state_reg)
            S_RST: begin
              if (per_reg == PER_W'(5)) begin
                done = 1'b1;
              end else begin
                tms_next  = (per_inc != PER_W'(5));
                trst_next = (per_inc == PER_W'(5));
              end
            end
            S_PRE: begin
              if (per_reg == ((op_reg == OP_IR) ? PER_W'(3) : PER_W'(2))) begin
                state_next = S_SHIFT;
                per_next   = '0;
                idx_next   = '0;
                tdi_next   = data_reg[0];
                tms_next   = (len_reg == LEN_W'(1));
              end else begin
                tms_next = (op_reg == OP_IR) && (per_inc == PER_W'(1));
              end
            end
            S_SHIFT: begin
              if (last_bit) begin
                state_next = S_POST;
                per_next   = '0;
                tms_next   = 1'b1;
                tdi_next   = 1'b0;
              end else begin
                idx_next = idx_inc;
                tdi_next = data_reg[idx_inc];
                tms_next = (LEN_W'(idx_inc) == len_reg - LEN_W'(1));
              end
            end
            S_POST: begin
              if (per_reg == PER_W'(1))
                done = 1'b1;
              else
                tms_next = 1'b0;
            end
            S_RUN: begin
              if (per_inc == PER_W'(len_reg))
                done = 1'b1;
            end
            default: ;
          endcase
        end else begin
          high_next = high_reg;
        end

        if (done) begin
          state_next     = S_IDLE;
          rsp_valid_next = 1'b1;
          rsp_data_next  = cap_reg;
          cmd_ready_next = 1'b1;
          busy_next      = 1'b0;
          tms_next       = 1'b0;
          tdi_next       = 1'b0;
          trst_next      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      op_reg        <= '0;
      len_reg       <= '0;
      data_reg      <= '0;
      cap_reg       <= '0;
      rsp_data_reg  <= '0;
      div_reg       <= '0;
      per_reg       <= '0;
      idx_reg       <= '0;
      high_reg      <= 1'b0;
      tck_reg       <= 1'b0;
      tms_reg       <= 1'b1;
      tdi_reg       <= 1'b0;
      trst_reg      <= 1'b1;
      rsp_valid_reg <= 1'b0;
      cmd_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      len_reg       <= len_next;
      data_reg      <= data_next;
      cap_reg       <= cap_next;
      rsp_data_reg  <= rsp_data_next;
      div_reg       <= div_next;
      per_reg       <= per_next;
      idx_reg       <= idx_next;
      high_reg      <= high_next;
      tck_reg       <= tck_next;
      tms_reg       <= tms_next;
      tdi_reg       <= tdi_next;
      trst_reg      <= trst_next;
      rsp_valid_reg <= rsp_valid_next;
      cmd_ready_reg <= cmd_ready_next;
      busy_reg      <= busy_next;
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = busy_reg;
  assign tck       = tck_reg;
  assign tms       = tms_reg;
  assign tdi       = tdi_reg;
  assign trst      = trst_reg;
endmodule

// File: tb/tb_jtag_host_driver.sv
`timescale 1ns/1ps
// Bench for jtag_host_driver: a small TAP target model plus a per-command
// reference of the expected tms/tdi/trst pin sequences and response timing.
module tb_jtag_host_driver;
  localparam int MAX_LEN = 32;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [31:0] IDCODE = 32'h4BA0_0477;
  localparam logic [3:0]  IDC_INSTR = 4'b0001;

  logic               sys_clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'b00;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy, tck, tms, tdi, trst;
  logic               tdo;

  int n_cmp = 0;
  int n_bad = 0;
  int rsp_cnt = 0;

  jtag_host_driver #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .sys_clk(sys_clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .trst(trst),
    .tdo(tdo)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (rsp_valid) rsp_cnt++;

  // ---------------- TAP target model ----------------
  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
  localparam int UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;
  int          tap_st = TLR;
  logic [3:0]  ir = IDC_INSTR;
  logic [3:0]  ir_sr = '0;
  logic [31:0] dr_sr = '0;
  logic        tap_tdo = 1'b0;
  logic        rnd_tdo = 1'b0;
  int          tdo_mode = 0;   // 0 random, 1 constant one, 2 TAP model

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    if (!trst) begin
      tap_st <= TLR;
      ir     <= IDC_INSTR;
    end else begin
      case (tap_st)
        TLR:  ir <= IDC_INSTR;
        CIR:  ir_sr <= 4'b0001;
        SHIR: ir_sr <= {tdi, ir_sr[3:1]};
        UIR:  ir <= ir_sr;
        CDR:  dr_sr <= (ir == IDC_INSTR) ? IDCODE : 32'h0;
        SHDR: dr_sr <= (ir == IDC_INSTR) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
    end
  end

  always @(negedge tck) begin
    logic [31:0] r;
    r = $urandom;
    rnd_tdo <= r[0];
    tap_tdo <= (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;
  end

  assign tdo = (tdo_mode == 0) ? rnd_tdo : (tdo_mode == 1) ? 1'b1 : tap_tdo;

  // ---------------- pin recorder (one entry per tck period) ----------------
  logic rec_tms[$], rec_tdi[$], rec_trst[$], rec_tdo[$];
  always @(posedge tck) begin
    rec_tms.push_back(tms);
    rec_tdi.push_back(tdi);
    rec_trst.push_back(trst);
    rec_tdo.push_back(tdo);
  end

  // ---------------- reference model ----------------
  logic exp_tms[$], exp_tdi[$], exp_trst[$];
  int   exp_sh0, exp_shn;

  task automatic build_expect(input logic [1:0] op, input int len, input logic [31:0] data);
    int eff;
    exp_tms.delete(); exp_tdi.delete(); exp_trst.delete();
    exp_sh0 = 0;
    exp_shn = 0;
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    if (op == 2'b00) begin
      for (int k = 0; k < 6; k++) begin
        exp_tms.push_back(k != 5);
        exp_tdi.push_back(1'b0);
        exp_trst.push_back(k == 5);
      end
    end else if (op == 2'b11) begin
      for (int k = 0; k < eff; k++) begin
        exp_tms.push_back(1'b0);
        exp_tdi.push_back(1'b0);
        exp_trst.push_back(1'b1);
      end
    end else begin
      if (eff == 0) eff = 1;
      exp_tms.push_back(1'b1);
      if (op == 2'b01) exp_tms.push_back(1'b1);
      exp_tms.push_back(1'b0);
      exp_tms.push_back(1'b0);
      exp_sh0 = exp_tms.size();
      exp_shn = eff;
      for (int k = 0; k < eff; k++) exp_tms.push_back(k == eff - 1);
      exp_tms.push_back(1'b1);
      exp_tms.push_back(1'b0);
      for (int p = 0; p < exp_tms.size(); p++) begin
        exp_tdi.push_back((p >= exp_sh0 && p < exp_sh0 + eff) ? data[p - exp_sh0] : 1'b0);
        exp_trst.push_back(1'b1);
      end
    end
  endtask

  // Packs a bit sequence so it reads left-to-right in time order.
  function automatic logic [63:0] pack(input logic q[$]);
    logic [63:0] v = '0;
    foreach (q[k]) v = {v[62:0], q[k]};
    return v;
  endfunction

  function automatic logic [31:0] exp_rsp_bits();
    logic [31:0] v = '0;
    for (int i = 0; i < exp_shn; i++)
      if (exp_sh0 + i < rec_tdo.size()) v[i] = rec_tdo[exp_sh0 + i];
    return v;
  endfunction

  // Issues one command; lat is rsp_valid cycle minus accept cycle.
  task automatic issue(input logic [1:0] op, input int len, input logic [31:0] data,
                       output int lat, output logic [31:0] rdata);
    int guard;
    rec_tms.delete(); rec_tdi.delete(); rec_trst.delete(); rec_tdo.delete();
    @(negedge sys_clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge sys_clk);
      guard++;
    end
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 2000) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    rdata = rsp_data;
    $display("txn op=%0d len=%0d lat=%0d periods=%0d rsp=%08h", op, len, lat, rec_tms.size(), rdata);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    n_cmp++;
    if ({tck, tms, tdi, trst, cmd_ready, rsp_valid, busy} !== 7'b0101000 || rsp_data !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got tck/tms/tdi/trst/rdy/rv/busy=%b rsp=%h want 0101000 rsp=0",
               {tck, tms, tdi, trst, cmd_ready, rsp_valid, busy}, rsp_data);
    end
    @(negedge sys_clk);
    reset = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_on_release: got %b want 0", cmd_ready);
    end
    @(posedge sys_clk); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || tms !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_release: got rdy=%b tms=%b want rdy=1 tms=1", cmd_ready, tms);
    end
  endtask

  task automatic test_tap_reset();
    int lat;
    logic [31:0] rd;
    tdo_mode = 2;
    issue(2'b00, 0, 32'h0, lat, rd);
    n_cmp++;
    if (lat !== 1 + 6 * 2 * CLK_DIV) begin
      n_bad++;
      $display("FAIL tap_reset_latency: got %0d want %0d", lat, 1 + 6 * 2 * CLK_DIV);
    end
    n_cmp++;
    if (rec_tms.size() !== 6 || pack(rec_tms) !== 64'b111110) begin
      n_bad++;
      $display("FAIL tap_reset_tms: got n=%0d seq=%b want n=6 seq=111110", rec_tms.size(), pack(rec_tms));
    end
    n_cmp++;
    if (pack(rec_trst) !== 64'b000001) begin
      n_bad++;
      $display("FAIL tap_reset_trst: got %b want 000001", pack(rec_trst));
    end
    n_cmp++;
    if (tap_st !== RTI || tms !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL tap_reset_park: got tap=%0d tms=%b busy=%b want tap=%0d tms=0 busy=0", tap_st, tms, busy, RTI);
    end
  endtask

  task automatic test_shift_ir();
    int lat;
    logic [31:0] rd;
    tdo_mode = 1;
    issue(2'b01, 4, 32'b1010, lat, rd);
    n_cmp++;
    if (lat !== 41) begin
      n_bad++;
      $display("FAIL ir_latency: got %0d want 41", lat);
    end
    n_cmp++;
    if (rec_tms.size() !== 10 || pack(rec_tms) !== 64'b1100000110) begin
      n_bad++;
      $display("FAIL ir_tms: got n=%0d seq=%b want n=10 seq=1100000110", rec_tms.size(), pack(rec_tms));
    end
    n_cmp++;
    if (pack(rec_tdi) !== 64'b0000010100) begin
      n_bad++;
      $display("FAIL ir_tdi: got %b want 0000010100", pack(rec_tdi));
    end
    n_cmp++;
    if (rd !== 32'h0000_000F) begin
      n_bad++;
      $display("FAIL ir_rsp: got %h want 0000000f", rd);
    end
    n_cmp++;
    if (tms !== 1'b0) begin
      n_bad++;
      $display("FAIL ir_idle_tms: got %b want 0", tms);
    end
  endtask

  task automatic test_idcode();
    int lat;
    logic [31:0] rd;
    tdo_mode = 2;
    issue(2'b00, 0, 32'h0, lat, rd);
    issue(2'b01, 4, {28'h0, IDC_INSTR}, lat, rd);
    n_cmp++;
    if (rd !== 32'h0000_0001) begin
      n_bad++;
      $display("FAIL ir_capture: got %h want 00000001", rd);
    end
    issue(2'b10, 32, 32'h0, lat, rd);
    n_cmp++;
    if (rd !== IDCODE || lat !== 1 + 37 * 2 * CLK_DIV) begin
      n_bad++;
      $display("FAIL idcode_read: got %h lat=%0d want %h lat=%0d", rd, lat, IDCODE, 1 + 37 * 2 * CLK_DIV);
    end
    n_cmp++;
    if (tap_st !== RTI) begin
      n_bad++;
      $display("FAIL idcode_park: got tap=%0d want %0d", tap_st, RTI);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bad_hs, guard;
    tdo_mode = 0;
    @(negedge sys_clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = LEN_W'(8);
    cmd_data  = $urandom;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge sys_clk);
      guard++;
    end
    @(posedge sys_clk); #1;
    cmd_op  = 2'b11;
    cmd_len = LEN_W'(2);
    lat = 1;
    bad_hs = 0;
    while (!rsp_valid && lat < 400) begin
      if (cmd_ready !== 1'b0 || busy !== 1'b1) bad_hs++;
      @(posedge sys_clk); #1;
      lat++;
    end
    $display("txn op=2 len=8 lat=%0d (held valid)", lat);
    n_cmp++;
    if (bad_hs !== 0 || lat !== 1 + 13 * 2 * CLK_DIV) begin
      n_bad++;
      $display("FAIL b2b_first: got bad_hs=%0d lat=%0d want 0 and %0d", bad_hs, lat, 1 + 13 * 2 * CLK_DIV);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_rsp_cycle: got rdy=%b busy=%b want 1 0", cmd_ready, busy);
    end
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || tck !== 1'b0 || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second_start: got busy=%b tck=%b rdy=%b want 1 0 0", busy, tck, cmd_ready);
    end
    repeat (CLK_DIV) @(posedge sys_clk);
    #1;
    n_cmp++;
    if (tck !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_first_rise: got tck=%b want 1", tck);
    end
    lat = 1 + CLK_DIV;
    while (!rsp_valid && lat < 400) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    $display("txn op=3 len=2 lat=%0d (back-to-back)", lat);
    n_cmp++;
    if (lat !== 1 + 2 * 2 * CLK_DIV) begin
      n_bad++;
      $display("FAIL b2b_second_latency: got %0d want %0d", lat, 1 + 2 * 2 * CLK_DIV);
    end
  endtask

  task automatic test_boundaries();
    int lat;
    logic [31:0] rd, d;
    tdo_mode = 0;
    issue(2'b11, 0, 32'h0, lat, rd);
    n_cmp++;
    if (lat !== 1 || rec_tms.size() !== 0 || tck !== 1'b0 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL idle_len0: got lat=%0d edges=%0d tck=%b rsp=%h want 1 0 0 0", lat, rec_tms.size(), tck, rd);
    end
    @(posedge sys_clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rsp_pulse_width: got %b want 0", rsp_valid);
    end
    d = $urandom;
    build_expect(2'b10, 40, d);
    issue(2'b10, 40, d, lat, rd);
    n_cmp++;
    if (lat !== 1 + 37 * 2 * CLK_DIV || rec_tms.size() !== 37 || pack(rec_tdi) !== pack(exp_tdi)) begin
      n_bad++;
      $display("FAIL dr_len40_clamp: got lat=%0d n=%0d tdi=%h want lat=%0d n=37 tdi=%h",
               lat, rec_tms.size(), pack(rec_tdi), 1 + 37 * 2 * CLK_DIV, pack(exp_tdi));
    end
    n_cmp++;
    if (rd !== exp_rsp_bits()) begin
      n_bad++;
      $display("FAIL dr_len40_rsp: got %h want %h", rd, exp_rsp_bits());
    end
    d = $urandom;
    build_expect(2'b01, 0, d);
    issue(2'b01, 0, d, lat, rd);
    n_cmp++;
    if (lat !== 1 + 7 * 2 * CLK_DIV || pack(rec_tms) !== 64'b1100110 || rd !== exp_rsp_bits()) begin
      n_bad++;
      $display("FAIL ir_len0: got lat=%0d tms=%b rsp=%h want lat=%0d tms=1100110 rsp=%h",
               lat, pack(rec_tms), rd, 1 + 7 * 2 * CLK_DIV, exp_rsp_bits());
    end
  endtask

  task automatic test_random();
    int lat, len, exp_lat;
    logic [1:0] op;
    logic [31:0] rd, d;
    tdo_mode = 0;
    for (int n = 0; n < 24; n++) begin
      op  = 2'($urandom_range(3, 0));
      len = $urandom_range(40, 0);
      d   = $urandom;
      build_expect(op, len, d);
      issue(op, len, d, lat, rd);
      exp_lat = 1 + exp_tms.size() * 2 * CLK_DIV;
      n_cmp++;
      if (lat !== exp_lat) begin
        n_bad++;
        $display("FAIL rnd_latency[%0d]: op=%0d len=%0d got %0d want %0d", n, op, len, lat, exp_lat);
      end
      n_cmp++;
      if (rec_tms.size() !== exp_tms.size() || pack(rec_tms) !== pack(exp_tms)) begin
        n_bad++;
        $display("FAIL rnd_tms[%0d]: op=%0d len=%0d got n=%0d %h want n=%0d %h", n, op, len,
                 rec_tms.size(), pack(rec_tms), exp_tms.size(), pack(exp_tms));
      end
      n_cmp++;
      if (pack(rec_tdi) !== pack(exp_tdi) || pack(rec_trst) !== pack(exp_trst)) begin
        n_bad++;
        $display("FAIL rnd_tdi_trst[%0d]: got tdi=%h trst=%h want tdi=%h trst=%h", n,
                 pack(rec_tdi), pack(rec_trst), pack(exp_tdi), pack(exp_trst));
      end
      n_cmp++;
      if (rd !== exp_rsp_bits()) begin
        n_bad++;
        $display("FAIL rnd_rsp[%0d]: op=%0d len=%0d got %h want %h", n, op, len, rd, exp_rsp_bits());
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard, cnt0, lat;
    logic [31:0] rd;
    tdo_mode = 0;
    rec_tms.delete(); rec_tdi.delete(); rec_trst.delete(); rec_tdo.delete();
    @(negedge sys_clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = LEN_W'(8);
    cmd_data  = $urandom;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge sys_clk);
      guard++;
    end
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    guard = 0;
    // Shift bit 3 of a DR scan is tck period 6 (after the 3 preamble periods).
    while (rec_tms.size() < 7 && guard < 400) begin
      @(posedge sys_clk); #1;
      guard++;
    end
    n_cmp++;
    if (rec_tms.size() < 7) begin
      n_bad++;
      $display("FAIL mid_reset_reach_bit3: got %0d periods want 7", rec_tms.size());
    end
    cnt0 = rsp_cnt;
    reset = 1'b1;
    @(posedge sys_clk); #1;
    n_cmp++;
    if ({tck, tms, trst, busy, cmd_ready} !== 5'b01100 || rsp_data !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_values: got tck/tms/trst/busy/rdy=%b rsp=%h want 01100 rsp=0",
               {tck, tms, trst, busy, cmd_ready}, rsp_data);
    end
    @(negedge sys_clk);
    reset = 1'b0;
    repeat (60) @(posedge sys_clk);
    #1;
    n_cmp++;
    if (rsp_cnt !== cnt0) begin
      n_bad++;
      $display("FAIL mid_reset_no_rsp: got %0d pulses want 0", rsp_cnt - cnt0);
    end
    tdo_mode = 2;
    issue(2'b00, 0, 32'h0, lat, rd);
    n_cmp++;
    if (lat !== 1 + 6 * 2 * CLK_DIV || tap_st !== RTI) begin
      n_bad++;
      $display("FAIL mid_reset_recover: got lat=%0d tap=%0d want %0d %0d", lat, tap_st, 1 + 6 * 2 * CLK_DIV, RTI);
    end
  endtask

  initial begin
    test_reset();
    test_tap_reset();
    test_shift_ir();
    test_idcode();
    test_back_to_back();
    test_boundaries();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
